alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sits directly upstream of the ALU, between the decode stage and the ALU.
- Accepts one operation at a time (operands, opcode, destination tag) over a valid/ready handshake.
- Holds the ALU inputs stable and gates the multiply/divide clock enable. Multi-cycle ops wait for the ALU's complete signal; single-cycle ops wait a fixed latency.
- Captures the ALU answer and presents it downstream over a second valid/ready handshake.

Parameters:
- FIX_LAT, 2, cycles from ALU issue to sampling answer for single-cycle opcodes (≥1).
- SETTLE, 2, cycles after asserting mul_div_en during which alu_complete is ignored (masks stale complete).
- TIMEOUT, 255, max WAIT_DONE cycles before abort (8-bit counter).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  decode has an op
- in_ready  out  1  block can accept an op
- in_op1  in  32  operand 1
- in_op2  in  32  operand 2
- in_opcode  in  5  ALU opcode
- in_rd  in  5  destination register tag
- alu_op1  out  32  to ALU operator_1
- alu_op2  out  32  to ALU operator_2
- alu_opcode  out  5  to ALU opcode
- mul_div_en  out  1  to ALU clk_ctl_mul_div
- alu_answer  in  32  from ALU answer
- alu_complete  in  1  from ALU complete_signal
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_result  out  32  captured answer
- out_rd  out  5  tag of result
- out_timeout  out  1  result aborted by timeout (out_result=0)

Behaviour:
- Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, mul_div_en=0, alu_op1/alu_op2=0, alu_opcode=5'b00000, out_result=0, out_rd=0, out_timeout=0, counters=0.
- Multi-cycle class: opcode 5'b00010..5'b01001 inclusive (mul 00010–00101, div 00110–01001). All other opcodes are fixed-latency.
- IDLE: in_ready=1. On in_valid&in_ready, register op1/op2/opcode/rd into the alu_* and tag registers; in_ready drops next cycle.
  - Multi-cycle → SETTLE with mul_div_en=1 and cnt=0.
  - Otherwise → WAIT_FIX with cnt=0.
- WAIT_FIX: cnt increments each cycle. When cnt==FIX_LAT-1, capture alu_answer into out_result and go to RESP. Accepting in cycle N gives capture at end of cycle N+FIX_LAT.
- SETTLE: mul_div_en=1. alu_complete is ignored. After SETTLE cycles → WAIT_DONE with the timeout counter cleared.
- WAIT_DONE: mul_div_en=1.
  - alu_complete=1: capture alu_answer, out_timeout=0, mul_div_en←0, → RESP.
  - Else, timeout counter reaches TIMEOUT: out_result=0, out_timeout=1, mul_div_en←0, → RESP.
  - Complete and timeout in the same cycle: complete wins.
- RESP: out_valid=1, with out_result/out_rd/out_timeout held stable. On out_valid&out_ready → IDLE: out_valid←0, in_ready←1 next cycle.
  - No same-cycle bypass. Minimum gap between accepts is FIX_LAT+2 cycles.
- alu_op1/alu_op2/alu_opcode stay stable from accept until the next accept; they are not cleared on return to IDLE.
- mul_div_en is registered and is high only in SETTLE/WAIT_DONE. It is never high for fixed-latency ops.
- in_valid while busy: ignored, in_ready=0. Inputs need not be held by the block; upstream must hold until handshake.
- out_ready held low: block stalls in RESP indefinitely with outputs unchanged.
- rst mid-operation: all state returns to reset values asynchronously. The in-flight op is dropped and no output is produced.
- Opcode values are passed through unchecked; unknown opcodes are treated as fixed-latency.

Test Plan:
- ADD, fixed latency: opcode 5'b00000, op1=5, op2=7, rd=3, out_ready=1; ALU model returns 12 → out_valid exactly FIX_LAT+1 cycles after accept, out_result=12, out_rd=3, mul_div_en never high.
- MUL with stale complete: opcode 5'b00010, ALU model holds complete=1 through SETTLE then low for 10 cycles then high with answer 0x0000_0063 → mul_div_en high from accept+1 until capture, out_result=0x63, out_timeout=0.
- Divider hang: opcode 5'b00110, complete held 0 → out_valid after SETTLE+TIMEOUT cycles, out_timeout=1, out_result=0, mul_div_en=0.
- Back-pressure: complete an op with out_ready=0 for 20 cycles → out_valid stays 1, out_result stable, in_ready=0, second in_valid ignored; release out_ready → second op accepted the cycle after in_ready returns to 1.
- Reset mid-op: assert rst during WAIT_DONE of a DIV → outputs immediately at reset values. After deassert, a new ADD 1+1 → out_result=2.
- Boundary opcodes: 5'b00001 and 5'b01010 take the fixed path; 5'b00010 and 5'b01001 take the multi-cycle path (check mul_div_en).

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and the ALU: holds operands, gates the mul/div
// clock enable, waits for a fixed latency or the ALU complete, and returns the answer.
module alu_issue_ctrl #(
    parameter int unsigned FIX_LAT = 2,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    input  logic [4:0]  in_opcode,
    input  logic [4:0]  in_rd,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [4:0]  alu_opcode,
    output logic        mul_div_en,
    input  logic [31:0] alu_answer,
    input  logic        alu_complete,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_timeout
);

    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 5;
    localparam int unsigned RW  = 5;
    localparam int unsigned CW  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FIX,
        S_SETTLE,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t          r_state,  w_state_nxt;
    logic [CW-1:0]   r_cnt,    w_cnt_nxt;
    logic [CW-1:0]   r_tcnt,   w_tcnt_nxt;
    logic [DW-1:0]   r_op1,    w_op1_nxt;
    logic [DW-1:0]   r_op2,    w_op2_nxt;
    logic [OPW-1:0]  r_opcode, w_opcode_nxt;
    logic [RW-1:0]   r_tag,    w_tag_nxt;
    logic [DW-1:0]   r_result, w_result_nxt;
    logic [RW-1:0]   r_out_rd, w_out_rd_nxt;
    logic            r_timeout,    w_timeout_nxt;
    logic            r_mul_div_en, w_mul_div_en_nxt;
    logic            r_in_ready,   w_in_ready_nxt;
    logic            r_out_valid,  w_out_valid_nxt;
    logic            w_is_multi;

    // Opcodes 2..9 are mul/div and complete on the ALU's own schedule
    assign w_is_multi = (in_opcode >= OPW'(2)) && (in_opcode <= OPW'(9));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_tcnt       <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_opcode     <= '0;
            r_tag        <= '0;
            r_result     <= '0;
            r_out_rd     <= '0;
            r_timeout    <= 1'b0;
            r_mul_div_en <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_op1        <= w_op1_nxt;
            r_op2        <= w_op2_nxt;
            r_opcode     <= w_opcode_nxt;
            r_tag        <= w_tag_nxt;
            r_result     <= w_result_nxt;
            r_out_rd     <= w_out_rd_nxt;
            r_timeout    <= w_timeout_nxt;
            r_mul_div_en <= w_mul_div_en_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_out_valid  <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_tcnt_nxt       = r_tcnt;
        w_op1_nxt        = r_op1;
        w_op2_nxt        = r_op2;
        w_opcode_nxt     = r_opcode;
        w_tag_nxt        = r_tag;
        w_result_nxt     = r_result;
        w_out_rd_nxt     = r_out_rd;
        w_timeout_nxt    = r_timeout;
        w_mul_div_en_nxt = r_mul_div_en;

        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_op1_nxt    = in_op1;
                    w_op2_nxt    = in_op2;
                    w_opcode_nxt = in_opcode;
                    w_tag_nxt    = in_rd;
                    w_cnt_nxt    = '0;
                    if (w_is_multi) begin
                        w_state_nxt      = S_SETTLE;
                        w_mul_div_en_nxt = 1'b1;
                    end else begin
                        w_state_nxt      = S_WAIT_FIX;
                    end
                end
            end
            S_WAIT_FIX: begin
                if (r_cnt == CW'(FIX_LAT - 1)) begin
                    w_result_nxt  = alu_answer;
                    w_out_rd_nxt  = r_tag;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = S_RESP;
                end else begin
                    w_cnt_nxt     = r_cnt + CW'(1);
                end
            end
            // A complete left over from the previous mul/div is masked here
            S_SETTLE: begin
                if (r_cnt == CW'(SETTLE - 1)) begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = S_WAIT_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (alu_complete) begin
                    w_result_nxt     = alu_answer;
                    w_out_rd_nxt     = r_tag;
                    w_timeout_nxt    = 1'b0;
                    w_mul_div_en_nxt = 1'b0;
                    w_state_nxt      = S_RESP;
                end else if (r_tcnt == CW'(TIMEOUT - 1)) begin
                    w_result_nxt     = '0;
                    w_out_rd_nxt     = r_tag;
                    w_timeout_nxt    = 1'b1;
                    w_mul_div_en_nxt = 1'b0;
                    w_state_nxt      = S_RESP;
                end else begin
                    w_tcnt_nxt       = r_tcnt + CW'(1);
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_RESP);
    end

    assign in_ready    = r_in_ready;
    assign alu_op1     = r_op1;
    assign alu_op2     = r_op2;
    assign alu_opcode  = r_opcode;
    assign mul_div_en  = r_mul_div_en;
    assign out_valid   = r_out_valid;
    assign out_result  = r_result;
    assign out_rd      = r_out_rd;
    assign out_timeout = r_timeout;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: scripted ALU model, expected results queued
// at accept and compared when the result handshake happens.
module tb_alu_issue_ctrl;

    localparam int unsigned FIX_LAT = 2;
    localparam int unsigned SETTLE  = 2;
    localparam int unsigned TIMEOUT = 255;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        tmo;
    } exp_t;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [31:0] in_op1, in_op2;
    logic [4:0]  in_opcode, in_rd;
    logic [31:0] alu_op1, alu_op2, alu_answer, out_result;
    logic [4:0]  alu_opcode, out_rd;
    logic        mul_div_en, alu_complete, out_valid, out_ready, out_timeout;

    logic        tb_use_add;
    logic [31:0] tb_ans;
    logic        tb_cmp;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    // ALU model: adds the held operands for fixed ops, scripted answer otherwise
    assign alu_answer   = tb_use_add ? (alu_op1 + alu_op2) : tb_ans;
    assign alu_complete = tb_cmp;

    alu_issue_ctrl #(.FIX_LAT(FIX_LAT), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_opcode(in_opcode), .in_rd(in_rd),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
        .mul_div_en(mul_div_en), .alu_answer(alu_answer), .alu_complete(alu_complete),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_timeout(out_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output bit ok);
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_opcode = opc;
        in_op1    = a;
        in_op2    = b;
        in_rd     = rd;
        for (int i = 0; i < 50; i++) begin
            if (in_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // lat=1 means out_valid is visible in the cycle right after the accept edge
    task automatic wait_valid(input int bound, output int lat, output bit saw_mde);
        lat     = 1;
        saw_mde = (mul_div_en === 1'b1);
        while (out_valid !== 1'b1 && lat < bound) begin
            tick();
            lat++;
            if (mul_div_en === 1'b1) saw_mde = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (mul_div_en !== 1'b0) begin n_fail++; $display("FAIL rst_mul_div_en got=%b exp=0", mul_div_en); end
        n_checks++;
        if ({alu_op1, alu_op2, alu_opcode} !== 69'd0) begin
            n_fail++; $display("FAIL rst_alu_regs got=%h/%h/%h exp=0", alu_op1, alu_op2, alu_opcode);
        end
        n_checks++;
        if ({out_result, out_rd, out_timeout} !== 38'd0) begin
            n_fail++; $display("FAIL rst_out_regs got=%h/%h/%b exp=0", out_result, out_rd, out_timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_rst_idle got=rdy%b vld%b exp=rdy1 vld0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        bit ok, saw; int lat; exp_t e;
        tb_use_add = 1'b1;
        accept(5'b00000, 32'd5, 32'd7, 5'd3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL add_accept got=0 exp=1"); end
        sb.push_back('{32'd12, 5'd3, 1'b0});
        n_checks++;
        if ({alu_op1, alu_op2, alu_opcode} !== {32'd5, 32'd7, 5'd0}) begin
            n_fail++; $display("FAIL add_alu_inputs got=%0d/%0d/%0d exp=5/7/0", alu_op1, alu_op2, alu_opcode);
        end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_busy_ready got=%b exp=0", in_ready); end
        wait_valid(20, lat, saw);
        n_checks++; if (lat != FIX_LAT + 1) begin n_fail++; $display("FAIL add_latency got=%0d exp=%0d", lat, FIX_LAT + 1); end
        n_checks++; if (saw) begin n_fail++; $display("FAIL add_mul_div_en got=1 exp=0"); end
        if (sb.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL add_sb_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, out_result, out_rd, out_timeout} !== {1'b1, e.res, e.rd, e.tmo}) begin
                n_fail++; $display("FAIL add_result got=v%b %h rd%0d t%b exp=v1 %h rd%0d t%b",
                                   out_valid, out_result, out_rd, out_timeout, e.res, e.rd, e.tmo);
            end
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL add_release got=vld%b rdy%b exp=vld0 rdy1", out_valid, in_ready);
        end
    endtask

    task automatic test_mul_stale();
        bit ok; int bad; exp_t e;
        tb_use_add = 1'b0;
        tb_ans     = 32'hDEAD_BEEF;
        tb_cmp     = 1'b1;
        accept(5'b00010, 32'd11, 32'd9, 5'd4, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mul_accept got=0 exp=1"); end
        sb.push_back('{32'h0000_0063, 5'd4, 1'b0});
        bad = 0;
        for (int i = 0; i < int'(SETTLE); i++) begin
            if (mul_div_en !== 1'b1 || out_valid !== 1'b0) bad++;
            tick();
        end
        tb_cmp = 1'b0;
        tb_ans = 32'h0000_0063;
        for (int i = 0; i < 10; i++) begin
            if (mul_div_en !== 1'b1 || out_valid !== 1'b0) bad++;
            tick();
        end
        tb_cmp = 1'b1;
        if (mul_div_en !== 1'b1) bad++;
        tick();
        tb_cmp = 1'b0;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mul_wait_window got=%0d bad cycles exp=0", bad); end
        n_checks++; if (mul_div_en !== 1'b0) begin n_fail++; $display("FAIL mul_en_after got=%b exp=0", mul_div_en); end
        if (sb.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL mul_sb_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, out_result, out_rd, out_timeout} !== {1'b1, e.res, e.rd, e.tmo}) begin
                n_fail++; $display("FAIL mul_result got=v%b %h rd%0d t%b exp=v1 %h rd%0d t%b",
                                   out_valid, out_result, out_rd, out_timeout, e.res, e.rd, e.tmo);
            end
        end
        tick();
    endtask

    task automatic test_div_hang();
        bit ok, saw; int lat; exp_t e;
        tb_use_add = 1'b0;
        tb_ans     = 32'h0000_1234;
        tb_cmp     = 1'b0;
        accept(5'b00110, 32'd100, 32'd3, 5'd5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL div_accept got=0 exp=1"); end
        sb.push_back('{32'd0, 5'd5, 1'b1});
        wait_valid(600, lat, saw);
        n_checks++;
        if (lat != SETTLE + TIMEOUT + 1) begin
            n_fail++; $display("FAIL div_timeout_latency got=%0d exp=%0d", lat, SETTLE + TIMEOUT + 1);
        end
        n_checks++; if (mul_div_en !== 1'b0) begin n_fail++; $display("FAIL div_en_after got=%b exp=0", mul_div_en); end
        if (sb.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL div_sb_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, out_result, out_rd, out_timeout} !== {1'b1, e.res, e.rd, e.tmo}) begin
                n_fail++; $display("FAIL div_result got=v%b %h rd%0d t%b exp=v1 %h rd%0d t%b",
                                   out_valid, out_result, out_rd, out_timeout, e.res, e.rd, e.tmo);
            end
        end
        tick();
    endtask

    task automatic test_back_pressure();
        bit ok, saw; int lat, bad; exp_t e;
        tb_use_add = 1'b1;
        out_ready  = 1'b0;
        accept(5'b00000, 32'd10, 32'd20, 5'd7, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_accept got=0 exp=1"); end
        sb.push_back('{32'd30, 5'd7, 1'b0});
        wait_valid(20, lat, saw);
        in_valid = 1'b1; in_op1 = 32'd1; in_op2 = 32'd2; in_opcode = 5'd0; in_rd = 5'd9;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || out_result !== 32'd30 || out_rd !== 5'd7 ||
                in_ready !== 1'b0 || alu_op1 !== 32'd10) bad++;
            tick();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_stall got=%0d bad cycles exp=0", bad); end
        if (sb.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL bp_sb_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, out_result, out_rd, out_timeout} !== {1'b1, e.res, e.rd, e.tmo}) begin
                n_fail++; $display("FAIL bp_result1 got=v%b %h rd%0d t%b exp=v1 %h rd%0d t%b",
                                   out_valid, out_result, out_rd, out_timeout, e.res, e.rd, e.tmo);
            end
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_op1 !== 32'd10) begin
            n_fail++; $display("FAIL bp_idle got=rdy%b vld%b op1=%0d exp=rdy1 vld0 op1=10", in_ready, out_valid, alu_op1);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || alu_op1 !== 32'd1 || alu_op2 !== 32'd2) begin
            n_fail++; $display("FAIL bp_second_accept got=rdy%b %0d/%0d exp=rdy0 1/2", in_ready, alu_op1, alu_op2);
        end
        sb.push_back('{32'd3, 5'd9, 1'b0});
        wait_valid(20, lat, saw);
        if (sb.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL bp_sb2_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, out_result, out_rd, out_timeout} !== {1'b1, e.res, e.rd, e.tmo}) begin
                n_fail++; $display("FAIL bp_result2 got=v%b %h rd%0d t%b exp=v1 %h rd%0d t%b",
                                   out_valid, out_result, out_rd, out_timeout, e.res, e.rd, e.tmo);
            end
        end
        tick();
    endtask

    task automatic test_reset_midop();
        bit ok, saw; int lat, bad; exp_t e;
        tb_use_add = 1'b0;
        tb_cmp     = 1'b0;
        accept(5'b00111, 32'd50, 32'd5, 5'd6, ok);
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (!ok || mul_div_en !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got=ok%b en%b exp=ok1 en1", ok, mul_div_en); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (mul_div_en !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ctrl got=en%b rdy%b vld%b exp=en0 rdy1 vld0", mul_div_en, in_ready, out_valid);
        end
        n_checks++;
        if ({alu_op1, alu_op2, alu_opcode, out_result, out_rd, out_timeout} !== 107'd0) begin
            n_fail++; $display("FAIL rmid_regs got=%h/%h/%h/%h/%h/%b exp=0", alu_op1, alu_op2, alu_opcode, out_result, out_rd, out_timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rmid_dropped got=%0d exp=0", bad); end
        tb_use_add = 1'b1;
        accept(5'b00000, 32'd1, 32'd1, 5'd2, ok);
        sb.push_back('{32'd2, 5'd2, 1'b0});
        wait_valid(20, lat, saw);
        n_checks++; if (lat != FIX_LAT + 1) begin n_fail++; $display("FAIL rmid_add_latency got=%0d exp=%0d", lat, FIX_LAT + 1); end
        if (sb.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL rmid_sb_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, out_result, out_rd, out_timeout} !== {1'b1, e.res, e.rd, e.tmo}) begin
                n_fail++; $display("FAIL rmid_result got=v%b %h rd%0d t%b exp=v1 %h rd%0d t%b",
                                   out_valid, out_result, out_rd, out_timeout, e.res, e.rd, e.tmo);
            end
        end
        tick();
    endtask

    task automatic test_boundary();
        logic [4:0] opcs  [4];
        bit         multi [4];
        bit ok, saw; int lat, exp_lat; exp_t e;
        opcs  = '{5'b00001, 5'b01010, 5'b00010, 5'b01001};
        multi = '{1'b0, 1'b0, 1'b1, 1'b1};
        tb_use_add = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tb_ans = 32'h100 + 32'(i);
            tb_cmp = 1'b1;
            accept(opcs[i], 32'd0, 32'd0, 5'(i + 10), ok);
            sb.push_back('{32'h100 + 32'(i), 5'(i + 10), 1'b0});
            wait_valid(20, lat, saw);
            exp_lat = multi[i] ? int'(SETTLE) + 2 : int'(FIX_LAT) + 1;
            n_checks++;
            if (saw != multi[i]) begin n_fail++; $display("FAIL bnd_en op=%b got=%b exp=%b", opcs[i], saw, multi[i]); end
            n_checks++;
            if (lat != exp_lat) begin n_fail++; $display("FAIL bnd_latency op=%b got=%0d exp=%0d", opcs[i], lat, exp_lat); end
            if (sb.size() == 0) begin
                n_checks++; n_fail++; $display("FAIL bnd_sb_empty got=0 exp=1");
            end else begin
                e = sb.pop_front();
                n_checks++;
                if ({out_valid, out_result, out_rd, out_timeout} !== {1'b1, e.res, e.rd, e.tmo}) begin
                    n_fail++; $display("FAIL bnd_result op=%b got=v%b %h rd%0d t%b exp=v1 %h rd%0d t%b",
                                       opcs[i], out_valid, out_result, out_rd, out_timeout, e.res, e.rd, e.tmo);
                end
            end
            tick();
        end
        tb_cmp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op1     = '0;
        in_op2     = '0;
        in_opcode  = '0;
        in_rd      = '0;
        out_ready  = 1'b1;
        tb_use_add = 1'b1;
        tb_ans     = '0;
        tb_cmp     = 1'b0;
        test_reset();
        test_add();
        test_mul_stale();
        test_div_hang();
        test_back_pressure();
        test_reset_midop();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
